// File: rtl/addsub_sched.sv
// addsub_sched: round-robin scheduler sharing one registered add/sub datapath
// among N_REQ requesters. The response is returned with the owner ID over a
// valid/ready port that can be back-pressured, and completed responses are counted.
// Optional build macro ADDSUB_SCHED_SAT_EN selects saturating unsigned results.
// Leaving it undefined gives modulo 2^WIDTH wrap-around.
module addsub_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_dataa,
  input  logic [N_REQ*WIDTH-1:0] req_datab,
  input  logic [N_REQ-1:0]       req_add_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_carry,
  output logic [15:0]            ops_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]       r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_rsp_id_p1;
  logic [WIDTH-1:0] r_rsp_result_p1;
  logic             r_rsp_carry_p1;
  logic [15:0]      r_ops_count;

  logic             w_can_issue;
  logic             w_grant_vld;
  logic [IDW-1:0]   w_grant_idx;
  logic [IDW:0]     w_scan;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_p0;
  logic [WIDTH-1:0] w_b_p0;
  logic             w_add_p0;
  logic [WIDTH:0]   w_sum_p0;
  logic [WIDTH-1:0] w_res_p0;

  // Full-width add or subtract; the extra MSB is the carry (add) or borrow (sub, set iff A<B).
  function automatic logic [WIDTH:0] f_arith(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic add);
    logic [WIDTH:0] s;
    if (add) s = {1'b0, a} + {1'b0, b};
    else     s = {1'b0, a} - {1'b0, b};
    return s;
  endfunction

`ifdef ADDSUB_SCHED_SAT_EN
  // Clamp to all-ones on add overflow and to zero on subtract borrow.
  function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH:0] s, input logic add);
    logic [WIDTH-1:0] r;
    r = s[WIDTH-1:0];
    if (s[WIDTH]) r = add ? '1 : '0;
    return r;
  endfunction
`else
  // Wrap-around: keep the low WIDTH bits.
  function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH:0] s);
    return s[WIDTH-1:0];
  endfunction
`endif

  assign w_can_issue = (r_state == IDLE) || rsp_ready;

  // Round-robin grant: first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(N_REQ)) w_scan = w_scan - (IDW+1)'(N_REQ);
      if (!w_grant_vld && req_valid[w_scan[IDW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan[IDW-1:0];
      end
    end
  end

  assign w_accept = w_grant_vld && w_can_issue;

  // One-hot ready toward the granted requester, only when the response slot can take a result.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant_idx] = 1'b1;
  end

  // Operand mux for the granted requester, followed by the shared arithmetic.
  always_comb begin
    w_a_p0   = '0;
    w_b_p0   = '0;
    w_add_p0 = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_a_p0   = req_dataa[i*WIDTH +: WIDTH];
        w_b_p0   = req_datab[i*WIDTH +: WIDTH];
        w_add_p0 = req_add_sub[i];
      end
    end
    w_sum_p0 = f_arith(w_a_p0, w_b_p0, w_add_p0);
`ifdef ADDSUB_SCHED_SAT_EN
    w_res_p0 = f_sat(w_sum_p0, w_add_p0);
`else
    w_res_p0 = f_sat(w_sum_p0);
`endif
  end

  // ---- p0 -> p1: response register and IDLE/FULL state ----
  // Response slot: load on accept (even while draining), empty on a drain with no accept, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_rsp_id_p1     <= '0;
      r_rsp_result_p1 <= '0;
      r_rsp_carry_p1  <= 1'b0;
    end else if (w_accept) begin
      r_state         <= FULL;
      r_rsp_id_p1     <= w_grant_idx;
      r_rsp_result_p1 <= w_res_p0;
      r_rsp_carry_p1  <= w_sum_p0[WIDTH];
    end else if (rsp_ready) begin
      r_state <= IDLE;
    end
  end

  // Round-robin pointer moves just past the accepted requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_grant_idx == IDW'(N_REQ-1)) ? '0 : w_grant_idx + IDW'(1);
    end
  end

  // Completed-response counter, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ops_count <= '0;
    end else if ((r_state == FULL) && rsp_ready) begin
      r_ops_count <= r_ops_count + 16'd1;
    end
  end

  assign rsp_valid  = (r_state == FULL);
  assign rsp_id     = r_rsp_id_p1;
  assign rsp_result = r_rsp_result_p1;
  assign rsp_carry  = r_rsp_carry_p1;
  assign ops_count  = r_ops_count;

endmodule

// File: tb/tb_addsub_sched.sv
// Testbench for addsub_sched (N_REQ=4, WIDTH=8). Expected results follow
// ADDSUB_SCHED_SAT_EN when the bench is compiled with that macro.
module tb_addsub_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dataa;
  logic [N*W-1:0] req_datab;
  logic [N-1:0]   req_add_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry;
  logic [15:0]    ops_count;

  int n_chk  = 0;
  int n_fail = 0;

  addsub_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dataa(req_dataa), .req_datab(req_datab), .req_add_sub(req_add_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       add;
    logic [7:0] res_wrap;
    logic [7:0] res_sat;
    logic       carry;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic add);
    req_dataa[id*W +: W] = a;
    req_datab[id*W +: W] = b;
    req_add_sub[id]      = add;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_res;
  logic [3:0] exp_onehot;
  int         g;

  initial begin
    vecs[0] = '{2, 8'h01, 8'h01, 1'b1, 8'h02, 8'h02, 1'b0};
    vecs[1] = '{0, 8'hFF, 8'h01, 1'b1, 8'h00, 8'hFF, 1'b1};
    vecs[2] = '{1, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b1};
    vecs[3] = '{3, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{2, 8'h80, 8'h7F, 1'b1, 8'hFF, 8'hFF, 1'b0};
    vecs[5] = '{1, 8'h80, 8'h80, 1'b1, 8'h00, 8'hFF, 1'b1};
    vecs[6] = '{0, 8'h50, 8'h30, 1'b0, 8'h20, 8'h20, 1'b0};
    vecs[7] = '{3, 8'h30, 8'h50, 1'b0, 8'hE0, 8'h00, 1'b1};

    rst_n = 1'b0; req_valid = '0; req_dataa = '0; req_datab = '0;
    req_add_sub = '0; rsp_ready = 1'b1;
    tick(); tick();
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset rsp_carry", rsp_carry, 0);
    chk("reset ops_count", ops_count, 0);
    chk("reset req_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Table: single requester per vector, back-to-back with rsp_ready high.
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].add);
      req_valid = 4'(1 << vecs[i].id);
      #1;
      chk($sformatf("v%0d req_ready", i), req_ready, 32'(1 << vecs[i].id));
      tick();
      req_valid = '0;
`ifdef ADDSUB_SCHED_SAT_EN
      exp_res = vecs[i].res_sat;
`else
      exp_res = vecs[i].res_wrap;
`endif
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d rsp_id", i), rsp_id, vecs[i].id);
      chk($sformatf("v%0d rsp_result", i), rsp_result, exp_res);
      chk($sformatf("v%0d rsp_carry", i), rsp_carry, vecs[i].carry);
    end
    tick();
    chk("table drained rsp_valid", rsp_valid, 0);
    chk("table ops_count", ops_count, 8);

    // Fairness: all four requesters valid, grants 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 * i + 1), 8'(i), 1'b1);
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      g = c % N;
      exp_onehot = 4'(1 << g);
      #1;
      chk($sformatf("fair c%0d req_ready", c), req_ready, exp_onehot);
      tick();
      if (c == 4) req_valid = '0;
      chk($sformatf("fair c%0d rsp_valid", c), rsp_valid, 1);
      chk($sformatf("fair c%0d rsp_id", c), rsp_id, g);
      chk($sformatf("fair c%0d rsp_result", c), rsp_result, 8'(8'h10 * g + 1 + g));
    end
    tick();
    chk("fair ops_count", ops_count, 5);
    chk("fair drained", rsp_valid, 0);

    // Backpressure: rr_ptr now 1; requesters 0 and 2 valid -> 2 first.
    set_req(0, 8'h10, 8'h05, 1'b0);
    set_req(2, 8'h22, 8'h11, 1'b1);
    req_valid = 4'b0101;
    rsp_ready = 1'b0;
    #1;
    chk("bp first grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp c%0d req_ready", c), req_ready, 0);
      chk($sformatf("bp c%0d rsp_valid", c), rsp_valid, 1);
      chk($sformatf("bp c%0d rsp_id", c), rsp_id, 2);
      chk($sformatf("bp c%0d rsp_result", c), rsp_result, 8'h33);
      chk($sformatf("bp c%0d ops_count", c), ops_count, 5);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp release req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("bp reload rsp_valid", rsp_valid, 1);
    chk("bp reload rsp_id", rsp_id, 0);
    chk("bp reload rsp_result", rsp_result, 8'h0B);
    chk("bp reload rsp_carry", rsp_carry, 0);
    chk("bp reload ops_count", ops_count, 6);
    tick();
    chk("bp final ops_count", ops_count, 7);
    chk("bp final rsp_valid", rsp_valid, 0);

    // Reset while a response is pending.
    set_req(1, 8'h01, 8'h02, 1'b1);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    chk("midrst pending", rsp_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst ops_count", ops_count, 0);
    chk("midrst rsp_result", rsp_result, 0);
    set_req(3, 8'h05, 8'h01, 1'b1);
    req_valid = 4'b1010;
    #1;
    chk("post-reset grant lowest", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("post-reset rsp_id", rsp_id, 1);
    chk("post-reset rsp_result", rsp_result, 8'h03);
    tick();

    // Counter wrap: 65536 completions return ops_count to zero.
    do_reset();
    set_req(0, 8'h00, 8'h00, 1'b1);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int c = 0; c < 65536; c++) tick();
    chk("wrap ops_count ffff", ops_count, 16'hFFFF);
    req_valid = '0;
    tick();
    chk("wrap ops_count 0", ops_count, 16'h0000);
    chk("wrap rsp_valid", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
